instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Purpose:
//   Fetch/decode/execute sequencer for a small 16-bit instruction set. It
//   requests an instruction word at the current PC, latches it into IR,
//   decodes it into register addresses and datapath controls, and steers
//   the PC update (hold / increment / branch / jump) during execute.
//   A HALT opcode parks the controller until Reset.
//
// Build option:
//   ILLEGAL_TRAP_EN - when defined, reserved opcodes 1101/1110 raise Illegal
//                     and halt. When undefined they execute as NOP.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   PC_Addr    in   [5:0]  current program counter
//   Mem_Data   in   [15:0] instruction memory read data
//   Mem_Valid  in   Mem_Data valid (only looked at in FETCH)
//   Zero       in   function-unit zero flag (sampled during EXECUTE)
//   Negative   in   function-unit sign flag (sampled during EXECUTE)
//   Mem_Req    out  instruction read request (FETCH only)
//   Mem_Addr   out  [5:0]  instruction read address (= PC_Addr)
//   IR         out  [15:0] instruction register
//   PS         out  [1:0]  PC select: 00 hold, 01 inc, 10 branch, 11 jump
//   Extend     out  [5:0]  branch offset {IR[8:6], IR[2:0]}
//   DA/AA/BA   out  [2:0]  destination / A / B register addresses
//   FS         out  [3:0]  function select
//   RW/MW/MD   out  register write, memory write, memory-to-register
//   Halt       out  controller halted
//   Illegal    out  reserved opcode trapped
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------
//   FETCH   | Mem_Req high, wait for Mem_Valid, latch IR on exit
//   DECODE  | decode IR into DA/AA/BA/FS/RW/MW/MD and instruction kind
//   EXECUTE | one cycle: strobes active, PS driven from kind and flags
//   HALT    | everything frozen, Halt=1, exit only through Reset
// ---------------------------------------------------------------------------
module instr_fetch_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  PC_Addr,
    input  logic [15:0] Mem_Data,
    input  logic        Mem_Valid,
    input  logic        Zero,
    input  logic        Negative,
    output logic        Mem_Req,
    output logic [5:0]  Mem_Addr,
    output logic [15:0] IR,
    output logic [1:0]  PS,
    output logic [5:0]  Extend,
    output logic [2:0]  DA,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic [3:0]  FS,
    output logic        RW,
    output logic        MW,
    output logic        MD,
    output logic        Halt,
    output logic        Illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    // Instruction class as far as PC steering and halting are concerned.
    typedef enum logic [2:0] {
        K_SEQ  = 3'd0,
        K_BRZ  = 3'd1,
        K_BRN  = 3'd2,
        K_JMP  = 3'd3,
        K_HALT = 3'd4,
        K_TRAP = 3'd5
    } kind_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    state_t     state;
    kind_t      kind_q;
    logic [3:0] opcode;
    kind_t      kind_d;
    logic       is_alu;
    logic       is_ld;
    logic       is_st;

    assign opcode = IR[15:12];

    always_comb begin
        kind_d = K_SEQ;
        unique case (opcode)
            4'b1010:          kind_d = K_BRZ;
            4'b1011:          kind_d = K_BRN;
            4'b1100:          kind_d = K_JMP;
            4'b1111:          kind_d = K_HALT;
            4'b1101, 4'b1110: kind_d = TRAP_EN ? K_TRAP : K_SEQ;
            default:          kind_d = K_SEQ;
        endcase
    end

    assign is_alu = (opcode != 4'b0000) && (opcode[3] == 1'b0);
    assign is_ld  = (opcode == 4'b1000);
    assign is_st  = (opcode == 4'b1001);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_FETCH;
            kind_q  <= K_SEQ;
            IR      <= '0;
            DA      <= '0;
            AA      <= '0;
            BA      <= '0;
            FS      <= '0;
            RW      <= 1'b0;
            MW      <= 1'b0;
            MD      <= 1'b0;
            Halt    <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (Mem_Valid) begin
                        IR    <= Mem_Data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    DA      <= IR[11:9];
                    AA      <= IR[8:6];
                    BA      <= IR[5:3];
                    FS      <= is_alu ? opcode : 4'b0000;
                    RW      <= is_alu | is_ld;
                    MW      <= is_st;
                    MD      <= is_ld;
                    kind_q  <= kind_d;
                    // Raised here so it is already visible during EXECUTE.
                    Illegal <= (kind_d == K_TRAP);
                    state   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    // Write strobes are single-cycle pulses.
                    RW <= 1'b0;
                    MW <= 1'b0;
                    MD <= 1'b0;
                    if (kind_q == K_HALT || kind_q == K_TRAP) begin
                        Halt  <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    // PC select depends on the flags as they stand in the EXECUTE cycle,
    // so it is decoded combinationally from the registered kind.
    always_comb begin
        PS = PS_HOLD;
        if (state == S_EXECUTE) begin
            case (kind_q)
                K_SEQ:   PS = PS_INC;
                K_BRZ:   PS = Zero ? PS_BR : PS_INC;
                K_BRN:   PS = Negative ? PS_BR : PS_INC;
                K_JMP:   PS = PS_JMP;
                K_HALT:  PS = PS_HOLD;
                K_TRAP:  PS = PS_HOLD;
                default: PS = PS_INC;
            endcase
        end
    end

    assign Mem_Req  = (state == S_FETCH);
    assign Mem_Addr = PC_Addr;
    assign Extend   = {IR[8:6], IR[2:0]};

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [5:0]  PC_Addr;
    logic [15:0] Mem_Data;
    logic        Mem_Valid;
    logic        Zero;
    logic        Negative;
    logic        Mem_Req;
    logic [5:0]  Mem_Addr;
    logic [15:0] IR;
    logic [1:0]  PS;
    logic [5:0]  Extend;
    logic [2:0]  DA, AA, BA;
    logic [3:0]  FS;
    logic        RW, MW, MD, Halt, Illegal;

    int total = 0;
    int bad   = 0;

    instr_fetch_ctrl dut (
        .Clk(Clk), .Reset(Reset), .PC_Addr(PC_Addr), .Mem_Data(Mem_Data),
        .Mem_Valid(Mem_Valid), .Zero(Zero), .Negative(Negative),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .IR(IR), .PS(PS),
        .Extend(Extend), .DA(DA), .AA(AA), .BA(BA), .FS(FS),
        .RW(RW), .MW(MW), .MD(MD), .Halt(Halt), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reset pulse; returns #1 after the edge at which Reset is released,
    // i.e. in the first FETCH cycle.
    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // From FETCH: present data with Mem_Valid, step through DECODE and
    // return sampled in the EXECUTE cycle.
    task automatic go_execute(input logic [15:0] data);
        Mem_Valid = 1'b1;
        Mem_Data  = data;
        tick();
        Mem_Valid = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; PC_Addr = 6'd5; Mem_Data = 16'h1253; Mem_Valid = 1'b1;
        Zero = 1'b0; Negative = 1'b0;
        tick();
        tick();
        // reset values
        chk("rst_ir", IR, 16'h0000);
        chk("rst_regs", {7'b0, DA, AA, BA}, 16'h0000);
        chk("rst_fs", {12'b0, FS}, 16'h0000);
        chk("rst_strobes", {13'b0, RW, MW, MD}, 16'h0000);
        chk("rst_flags", {14'b0, Halt, Illegal}, 16'h0000);
        chk("rst_ps", {14'b0, PS}, 16'h0000);
        Reset = 1'b0;

        // ALU 1253: cycle 0 FETCH
        chk("alu_c0_req", {15'b0, Mem_Req}, 16'h0001);
        chk("alu_c0_addr", {10'b0, Mem_Addr}, 16'h0005);
        tick();
        // cycle 1 DECODE; valid/data here must be ignored
        Mem_Valid = 1'b1; Mem_Data = 16'hFFFF;
        chk("alu_c1_req", {15'b0, Mem_Req}, 16'h0000);
        chk("alu_c1_ir", IR, 16'h1253);
        chk("alu_c1_rw", {15'b0, RW}, 16'h0000);
        chk("alu_c1_ps", {14'b0, PS}, 16'h0000);
        tick();
        // cycle 2 EXECUTE
        chk("alu_c2_rw", {15'b0, RW}, 16'h0001);
        chk("alu_c2_fs", {12'b0, FS}, 16'h0001);
        chk("alu_c2_da", {13'b0, DA}, 16'h0001);
        chk("alu_c2_aa", {13'b0, AA}, 16'h0001);
        chk("alu_c2_ba", {13'b0, BA}, 16'h0002);
        chk("alu_c2_ps", {14'b0, PS}, 16'h0001);
        chk("alu_c2_mwmd", {14'b0, MW, MD}, 16'h0000);
        Mem_Valid = 1'b0;
        tick();
        chk("alu_c3_req", {15'b0, Mem_Req}, 16'h0001);
        chk("alu_c3_rw", {15'b0, RW}, 16'h0000);
        chk("alu_c3_ps", {14'b0, PS}, 16'h0000);
        chk("alu_c3_ir_kept", IR, 16'h1253);

        // Wait states: 4 cycles without valid, then valid on the 5th
        Mem_Data = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            PC_Addr = 6'(10 + i);
            Mem_Valid = (i == 4);
            #1;
            chk("wait_req", {15'b0, Mem_Req}, 16'h0001);
            chk("wait_addr", {10'b0, Mem_Addr}, 16'(10 + i));
            chk("wait_ps", {14'b0, PS}, 16'h0000);
            tick();
        end
        Mem_Valid = 1'b0;
        chk("wait_dec_req", {15'b0, Mem_Req}, 16'h0000);
        chk("wait_dec_ps", {14'b0, PS}, 16'h0000);
        tick();
        chk("wait_exe_ps", {14'b0, PS}, 16'h0001);
        tick();
        chk("wait_after_ps", {14'b0, PS}, 16'h0000);

        // BRZ: Zero only raised inside EXECUTE, must still take the branch
        Zero = 1'b0;
        go_execute(16'hA1C5);
        Zero = 1'b1;
        #1;
        chk("brz_taken_ps", {14'b0, PS}, 16'h0002);
        chk("brz_extend", {10'b0, Extend}, 16'h003D);
        chk("brz_rw", {15'b0, RW}, 16'h0000);
        tick();
        chk("brz_after_ps", {14'b0, PS}, 16'h0000);
        // Zero high during decode, low in EXECUTE -> not taken
        Zero = 1'b1;
        Mem_Valid = 1'b1; Mem_Data = 16'hA1C5;
        tick();
        Mem_Valid = 1'b0;
        tick();
        Zero = 1'b0;
        #1;
        chk("brz_not_taken_ps", {14'b0, PS}, 16'h0001);
        tick();

        // BRN
        Negative = 1'b1;
        go_execute(16'hB000);
        chk("brn_taken_ps", {14'b0, PS}, 16'h0002);
        tick();
        Negative = 1'b0;
        go_execute(16'hB000);
        chk("brn_not_taken_ps", {14'b0, PS}, 16'h0001);
        tick();

        // JMP
        go_execute(16'hC000);
        chk("jmp_ps", {14'b0, PS}, 16'h0003);
        tick();
        chk("jmp_after_ps", {14'b0, PS}, 16'h0000);
        chk("jmp_after_req", {15'b0, Mem_Req}, 16'h0001);

        // ST and LD
        Mem_Valid = 1'b1; Mem_Data = 16'h9000;
        tick();
        Mem_Valid = 1'b0;
        chk("st_dec_mw", {15'b0, MW}, 16'h0000);
        tick();
        chk("st_exe_strobes", {13'b0, RW, MW, MD}, 16'h0002);
        chk("st_exe_ps", {14'b0, PS}, 16'h0001);
        tick();
        chk("st_after_mw", {15'b0, MW}, 16'h0000);
        go_execute(16'h8000);
        chk("ld_exe_strobes", {13'b0, RW, MW, MD}, 16'h0005);
        chk("ld_exe_fs", {12'b0, FS}, 16'h0000);
        tick();

        // Reserved opcode
        go_execute(16'hD000);
`ifdef ILLEGAL_TRAP_EN
        chk("rsv_illegal", {15'b0, Illegal}, 16'h0001);
        chk("rsv_ps", {14'b0, PS}, 16'h0000);
        tick();
        chk("rsv_halt", {15'b0, Halt}, 16'h0001);
        chk("rsv_req", {15'b0, Mem_Req}, 16'h0000);
`else
        chk("rsv_illegal", {15'b0, Illegal}, 16'h0000);
        chk("rsv_ps", {14'b0, PS}, 16'h0001);
        tick();
        chk("rsv_halt", {15'b0, Halt}, 16'h0000);
        chk("rsv_req", {15'b0, Mem_Req}, 16'h0001);
`endif
        do_reset();
        chk("rsv_rst_illegal", {15'b0, Illegal}, 16'h0000);

        // HALT
        go_execute(16'hF000);
        chk("halt_exe_ps", {14'b0, PS}, 16'h0000);
        chk("halt_exe_flag", {15'b0, Halt}, 16'h0000);
        Mem_Valid = 1'b1; Mem_Data = 16'h1253;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_flag", {15'b0, Halt}, 16'h0001);
            chk("halt_ps", {14'b0, PS}, 16'h0000);
            chk("halt_req", {15'b0, Mem_Req}, 16'h0000);
            chk("halt_ir", IR, 16'hF000);
            chk("halt_strobes", {13'b0, RW, MW, MD}, 16'h0000);
        end
        Mem_Valid = 1'b0;
        do_reset();
        chk("halt_rst_flag", {15'b0, Halt}, 16'h0000);
        chk("halt_rst_req", {15'b0, Mem_Req}, 16'h0001);

        // Reset asserted in the middle of DECODE
        Mem_Valid = 1'b1; Mem_Data = 16'h1253;
        tick();
        Mem_Valid = 1'b0;
        chk("mid_dec_state", {15'b0, Mem_Req}, 16'h0000);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_req", {15'b0, Mem_Req}, 16'h0001);
        chk("mid_rst_ir", IR, 16'h0000);
        chk("mid_rst_rw", {15'b0, RW}, 16'h0000);
        tick();
        chk("mid_rst_rw_edge", {15'b0, RW}, 16'h0000);
        Reset = 1'b0;
        chk("mid_post_req", {15'b0, Mem_Req}, 16'h0001);
        tick();
        chk("mid_post_rw", {15'b0, RW}, 16'h0000);
        chk("mid_post_ps", {14'b0, PS}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
